// File: rtl/dsd_pkg.sv
// dsd_pkg: shared state encoding, defaults and burst sizing for the DSD DDRAM fetch path
package dsd_pkg;
    localparam int BURST_DEF = 8;
    localparam int ADDR_W    = 29;

    typedef enum logic [2:0] {IDLE, ARM, REQ, DATA, DRAIN} state_e;

    function automatic logic [7:0] burst_len(input logic [31:0] rem, input int burst);
        return (rem < 32'(burst)) ? rem[7:0] : 8'(burst);
    endfunction
endpackage

// File: rtl/dsd_fetch_ctrl.sv
// dsd_fetch_ctrl: fetches a track from DDRAM in FIFO-safe bursts and streams it into the sample FIFO
module dsd_fetch_ctrl
    import dsd_pkg::*;
#(
    parameter int BURST = BURST_DEF,
    parameter int LEN_W = 24
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic [7:0]        fifo_free,
    output logic              fifo_wr,
    output logic [63:0]       fifo_data,
    input  logic              ddram_busy,
    output logic [7:0]        ddram_burstcnt,
    output logic [ADDR_W-1:0] ddram_addr,
    output logic              ddram_rd,
    input  logic [63:0]       ddram_dout,
    input  logic              ddram_dout_ready,
    output logic              active,
    output logic              done
);
    state_e            state_q;
    logic [ADDR_W-1:0] cur_addr_q, addr_q;
    logic [LEN_W-1:0]  remaining_q;
    logic [7:0]        beat_q, blen_q, burstcnt_q;
    logic [7:0]        blen_d, beat_d;
    logic [63:0]       data_q;
    logic              rd_q, wr_q, done_q, active_q;
    logic              last_beat, last_burst;

    assign blen_d     = burst_len(32'(remaining_q), BURST);
    assign beat_d     = beat_q + 8'd1;
    assign last_beat  = beat_d == blen_q;
    assign last_burst = remaining_q == LEN_W'(blen_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            beat_q      <= '0;
            blen_q      <= '0;
            addr_q      <= '0;
            burstcnt_q  <= '0;
            data_q      <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            done_q      <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            wr_q     <= 1'b0;
            done_q   <= 1'b0;
            active_q <= state_q != IDLE;
            case (state_q)
                IDLE: if (start && !stop) begin
                    cur_addr_q  <= base_addr;
                    remaining_q <= length;
                    state_q     <= ARM;
                end
                ARM: if (stop) begin
                    state_q <= IDLE;
                end else if (remaining_q == '0) begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end else if (fifo_free >= blen_d) begin
                    rd_q       <= 1'b1;
                    addr_q     <= cur_addr_q;
                    burstcnt_q <= blen_d;
                    blen_q     <= blen_d;
                    state_q    <= REQ;
                end
                REQ: if (!ddram_busy) begin
                    rd_q    <= 1'b0;
                    beat_q  <= '0;
                    state_q <= stop ? DRAIN : DATA;
                end else if (stop) begin
                    rd_q    <= 1'b0;
                    state_q <= IDLE;
                end
                DATA: if (ddram_dout_ready) begin
                    beat_q <= beat_d;
                    wr_q   <= !stop;
                    data_q <= ddram_dout;
                    if (last_beat) begin
                        cur_addr_q  <= cur_addr_q + ADDR_W'(blen_q);
                        remaining_q <= remaining_q - LEN_W'(blen_q);
                        // the final burst exits directly so done fires once, alongside the last write
                        done_q      <= !stop && last_burst;
                        state_q     <= (stop || last_burst) ? IDLE : ARM;
                    end else if (stop) begin
                        state_q <= DRAIN;
                    end
                end else if (stop) begin
                    state_q <= DRAIN;
                end
                DRAIN: if (ddram_dout_ready) begin
                    beat_q <= beat_d;
                    if (last_beat) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fifo_wr        = wr_q;
    assign fifo_data      = data_q;
    assign ddram_rd       = rd_q;
    assign ddram_addr     = addr_q;
    assign ddram_burstcnt = burstcnt_q;
    assign active         = active_q;
    assign done           = done_q;
endmodule

// File: doc/dsd_fetch_ctrl.md
DSD_FETCH_CTRL -- requirements
Module: dsd_fetch_ctrl

Interface
REQ-001 SHALL have parameter BURST, default 8, meaning DDRAM burst length in 64-bit words (1..128).
REQ-002 SHALL have parameter LEN_W, default 24, meaning width of the track length counter in words.
REQ-003 clk  input  1  system clock; the only clock.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse that begins playback fetch; honoured only in IDLE.
REQ-006 stop  input  1  one-cycle pulse that aborts the fetch; honoured in any non-IDLE state.
REQ-007 base_addr  input  29  track start address in 64-bit words; sampled on an accepted start.
REQ-008 length  input  LEN_W  track length in words; sampled on an accepted start; 0 means empty track.
REQ-009 fifo_free  input  8  free word slots in the downstream sample FIFO.
REQ-010 fifo_wr  output  1  write strobe to the sample FIFO.
REQ-011 fifo_data  output  64  write data to the sample FIFO.
REQ-012 ddram_busy  input  1  DDRAM not ready to accept a command.
REQ-013 ddram_burstcnt  output  8  burst length of the current read.
REQ-014 ddram_addr  output  29  word address of the current read.
REQ-015 ddram_rd  output  1  read request.
REQ-016 ddram_dout  input  64  read data beat.
REQ-017 ddram_dout_ready  input  1  read data beat valid.
REQ-018 active  output  1  high in every state except IDLE.
REQ-019 done  output  1  one-cycle pulse when the last word of the track has been written to the FIFO.

Function
REQ-020 SHALL implement states IDLE, ARM, REQ, DATA and DRAIN.
REQ-021 IDLE->ARM on start; base_addr and length are latched into cur_addr and remaining.
REQ-022 ARM: if remaining==0, pulse done and go to IDLE; else if fifo_free>=blen, where blen=min(remaining,BURST), drive ddram_rd=1, ddram_addr=cur_addr and ddram_burstcnt=blen, and go to REQ.
REQ-023 REQ: hold ddram_rd, ddram_addr and ddram_burstcnt stable until a cycle with ddram_busy==0; in that cycle the request is accepted, ddram_rd drops on the next cycle, and the state goes to DATA with beat counter=0.
REQ-024 DATA: each ddram_dout_ready beat SHALL produce fifo_wr=1 and fifo_data=ddram_dout registered, one cycle of latency.
REQ-025 DATA: the beat that makes beat==blen SHALL add blen to cur_addr (29-bit wrap), subtract blen from remaining, and return to ARM.
REQ-026 SHALL never issue a burst whose length exceeds fifo_free at issue time, so the FIFO never overflows.
REQ-027 stop in ARM: go to IDLE next cycle.
REQ-028 stop in REQ before acceptance: drop ddram_rd and go to IDLE.
REQ-029 stop in REQ on the acceptance cycle, or in DATA: go to DRAIN; DRAIN counts the remaining beats of the burst with fifo_wr held 0, then goes to IDLE; done is not pulsed.
REQ-030 start and stop asserted together in IDLE: stop wins, and the block stays IDLE.
REQ-031 start outside IDLE SHALL be ignored.
REQ-032 ddram_dout_ready outside DATA and DRAIN SHALL be ignored.
REQ-033 done SHALL be asserted coincident with the final fifo_wr of the track (registered output).
REQ-034 active SHALL be registered and asserted from the cycle after an accepted start until the cycle after IDLE is re-entered.

Reset
REQ-035 On reset_n low the block SHALL go to IDLE immediately and clear ddram_rd, fifo_wr, done, active, ddram_addr, ddram_burstcnt, fifo_data, cur_addr, remaining and beat.
REQ-036 Reset deassertion SHALL not start a fetch; a fresh start pulse is required.
REQ-037 Reset mid-burst SHALL discard the burst without draining.

Structure
REQ-038 The state enum, the BURST default and the DDRAM address width SHALL live in the shared package dsd_pkg.
REQ-039 No sub-module is required; a single flat module with one FSM and three counters (cur_addr, remaining, beat).

Verification
REQ-040 start, base_addr=0x100, length=20, fifo_free=255, no busy -> bursts (0x100,8), (0x108,8), (0x110,4); 20 fifo_wr; done on the 20th write.
REQ-041 ddram_busy held high for 5 cycles during REQ -> ddram_rd, ddram_addr and ddram_burstcnt stable for all 5 cycles; exactly one request accepted.
REQ-042 fifo_free=7, BURST=8, length=16 -> no ddram_rd while fifo_free<8; the burst is issued the cycle after fifo_free becomes 8.
REQ-043 stop after 3 of 8 beats -> DRAIN; no fifo_wr for beats 4-8; IDLE after the 8th beat; no done; active low one cycle later.
REQ-044 length=0 -> done pulse with no ddram_rd; length=1 with base_addr=0x1FFFFFFF -> one burst of 1; cur_addr wraps to 0.
REQ-045 reset_n low during DATA -> all outputs 0 asynchronously; beats arriving after reset produce no fifo_wr.
